// File: rtl/uart_frame_decoder.sv
// uart_frame_decoder: parses SYNC/CMD/LEN/payload/CHK byte frames into 32-bit words held in a FWFT FIFO
// Ports: i_Clock, i_Reset (sync, active high); i_Rx_DV/i_Rx_Byte byte strobe from UART RX;
//  o_Cmd CMD byte of current/last frame; o_Word/o_Word_Valid/i_Word_Ready FIFO head handshake;
//  o_Frame_Done one-cycle end-of-frame pulse; o_Err_Code 0 ok, 1 checksum, 2 overflow, 3 timeout;
//  o_Busy high outside S_IDLE.
module uart_frame_decoder #(
  parameter logic [7:0] SYNC_BYTE = 8'hA5,
  parameter int FIFO_DEPTH = 16,
  parameter int TIMEOUT_CLKS = 100000
) (
  input  logic        i_Clock,
  input  logic        i_Reset,
  input  logic        i_Rx_DV,
  input  logic [7:0]  i_Rx_Byte,
  output logic [7:0]  o_Cmd,
  output logic [31:0] o_Word,
  output logic        o_Word_Valid,
  input  logic        i_Word_Ready,
  output logic        o_Frame_Done,
  output logic [1:0]  o_Err_Code,
  output logic        o_Busy
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int TW = $clog2(TIMEOUT_CLKS + 1);
  localparam logic [AW:0] FULL = (AW+1)'(FIFO_DEPTH);
  localparam logic [TW-1:0] GAP_MAX = TW'(TIMEOUT_CLKS - 1);
  typedef enum logic [2:0] {S_IDLE, S_CMD, S_LEN, S_PAYLOAD, S_CHK} state_t;
  state_t state, state_n;
  logic [7:0] chk, words_left;
  logic [1:0] byte_idx;
  logic [23:0] part;
  logic ovf;
  logic [TW-1:0] gap;
  logic [31:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] count;
  logic timeout, push, pop, push_ok, chk_done;
  // a byte arriving in the same cycle as the gap limit cancels the timeout
  assign timeout = state != S_IDLE && !i_Rx_DV && gap == GAP_MAX;
  assign push = i_Rx_DV && state == S_PAYLOAD && byte_idx == 2'd3;
  assign pop = o_Word_Valid && i_Word_Ready;
  assign push_ok = push && (count != FULL || pop);
  assign chk_done = i_Rx_DV && state == S_CHK;
  assign o_Word_Valid = count != '0;
  assign o_Word = o_Word_Valid ? mem[rd_ptr] : '0;
  assign o_Busy = state != S_IDLE;
  always_ff @(posedge i_Clock) state <= i_Reset ? S_IDLE : state_n;
  always_comb begin
    state_n = state;
    if (timeout)
      state_n = S_IDLE;
    else if (i_Rx_DV)
      case (state)
        S_IDLE:    state_n = i_Rx_Byte == SYNC_BYTE ? S_CMD : S_IDLE;
        S_CMD:     state_n = S_LEN;
        S_LEN:     state_n = i_Rx_Byte == 8'd0 ? S_CHK : S_PAYLOAD;
        S_PAYLOAD: state_n = byte_idx == 2'd3 && words_left == 8'd1 ? S_CHK : S_PAYLOAD;
        default:   state_n = S_IDLE;
      endcase
  end
  always_ff @(posedge i_Clock)
    if (i_Reset) begin
      o_Cmd <= '0;
      o_Frame_Done <= 1'b0;
      o_Err_Code <= '0;
      chk <= '0;
      words_left <= '0;
      byte_idx <= '0;
      part <= '0;
      ovf <= 1'b0;
      gap <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      o_Frame_Done <= timeout || chk_done;
      if (timeout)
        o_Err_Code <= 2'd3;
      else if (chk_done)
        o_Err_Code <= ovf ? 2'd2 : i_Rx_Byte != chk ? 2'd1 : 2'd0;
      gap <= (i_Rx_DV || timeout || state == S_IDLE) ? '0 : gap + TW'(1);
      if (i_Rx_DV)
        case (state)
          S_IDLE:
            if (i_Rx_Byte == SYNC_BYTE) begin
              chk <= '0;
              words_left <= '0;
              byte_idx <= '0;
              part <= '0;
              ovf <= 1'b0;
            end
          S_CMD: begin
            o_Cmd <= i_Rx_Byte;
            chk <= i_Rx_Byte;
          end
          S_LEN: begin
            chk <= chk ^ i_Rx_Byte;
            words_left <= i_Rx_Byte;
          end
          S_PAYLOAD: begin
            chk <= chk ^ i_Rx_Byte;
            // after three bytes part holds {b2,b1,b0}; the 4th byte completes the word directly
            part <= {i_Rx_Byte, part[23:8]};
            byte_idx <= byte_idx + 2'd1;
            if (byte_idx == 2'd3)
              words_left <= words_left - 8'd1;
          end
          default: ;
        endcase
      if (push && !push_ok)
        ovf <= 1'b1;
      if (push_ok)
        wr_ptr <= wr_ptr + AW'(1);
      if (pop)
        rd_ptr <= rd_ptr + AW'(1);
      count <= count + {{AW{1'b0}}, push_ok} - {{AW{1'b0}}, pop};
    end
  always_ff @(posedge i_Clock)
    if (push_ok)
      mem[wr_ptr] <= {i_Rx_Byte, part};
endmodule

// File: tb/tb_uart_frame_decoder.sv
// tb_uart_frame_decoder: self-checking bench for uart_frame_decoder against a frame-parsing reference model
module tb_uart_frame_decoder;
  localparam int DEPTH = 16;
  localparam int TMO = 64;
  typedef logic [7:0] bq_t[$];
  typedef logic [31:0] wq_t[$];
  logic i_Clock = 1'b0, i_Reset = 1'b1, i_Rx_DV = 1'b0, i_Word_Ready = 1'b1;
  logic [7:0] i_Rx_Byte = 8'h00;
  logic [7:0] o_Cmd;
  logic [31:0] o_Word;
  logic o_Word_Valid, o_Frame_Done, o_Busy;
  logic [1:0] o_Err_Code;
  int n_checks = 0, n_fail = 0, done_cnt = 0;
  logic valid_seen = 1'b0, rand_ready = 1'b0;
  wq_t got_q;
  uart_frame_decoder #(.SYNC_BYTE(8'hA5), .FIFO_DEPTH(DEPTH), .TIMEOUT_CLKS(TMO)) dut (
    .i_Clock(i_Clock), .i_Reset(i_Reset), .i_Rx_DV(i_Rx_DV), .i_Rx_Byte(i_Rx_Byte),
    .o_Cmd(o_Cmd), .o_Word(o_Word), .o_Word_Valid(o_Word_Valid), .i_Word_Ready(i_Word_Ready),
    .o_Frame_Done(o_Frame_Done), .o_Err_Code(o_Err_Code), .o_Busy(o_Busy)
  );
  always #5 i_Clock = ~i_Clock;
  always @(negedge i_Clock) begin
    if (o_Word_Valid === 1'b1 && i_Word_Ready) got_q.push_back(o_Word);
    if (o_Word_Valid === 1'b1) valid_seen = 1'b1;
    if (o_Frame_Done === 1'b1) done_cnt++;
  end
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got hang, required finish");
    $fatal(1);
  end
  function automatic void model(input bq_t b, input logic drain, output wq_t w, output logic [1:0] err, output logic [7:0] cmd);
    int s, len;
    logic [7:0] c;
    s = 0;
    while (s < b.size() && b[s] !== 8'hA5) s++;
    cmd = b[s+1];
    len = int'(b[s+2]);
    c = b[s+1] ^ b[s+2];
    w = {};
    for (int i = 0; i < len; i++) begin
      w.push_back({b[s+6+4*i], b[s+5+4*i], b[s+4+4*i], b[s+3+4*i]});
      for (int k = 0; k < 4; k++) c ^= b[s+3+4*i+k];
    end
    err = (!drain && len > DEPTH) ? 2'd2 : (c != b[s+3+4*len]) ? 2'd1 : 2'd0;
    while (!drain && w.size() > DEPTH) void'(w.pop_back());
  endfunction
  function automatic bq_t make_frame(input logic [7:0] cmd, input int len, input logic bad);
    bq_t b;
    logic [7:0] c, x;
    b = {8'hA5, cmd, 8'(len)};
    c = cmd ^ 8'(len);
    for (int i = 0; i < 4*len; i++) begin
      x = 8'($urandom);
      b.push_back(x);
      c ^= x;
    end
    b.push_back(bad ? c ^ 8'($urandom_range(1, 255)) : c);
    return b;
  endfunction
  task automatic tick();
    @(posedge i_Clock);
    #1;
    if (rand_ready) i_Word_Ready = 1'($urandom_range(0, 1));
  endtask
  task automatic send(input logic [7:0] b);
    i_Rx_DV = 1'b1;
    i_Rx_Byte = b;
    tick();
    i_Rx_DV = 1'b0;
    i_Rx_Byte = 8'($urandom);
  endtask
  task automatic send_frame(input bq_t b, input int maxgap);
    foreach (b[i]) begin
      repeat ($urandom_range(0, maxgap)) tick();
      send(b[i]);
    end
  endtask
  task automatic clear_obs();
    got_q.delete();
    done_cnt = 0;
    valid_seen = 1'b0;
  endtask
  task automatic drain();
    tick();
    rand_ready = 1'b0;
    i_Word_Ready = 1'b1;
    for (int i = 0; i < 4*DEPTH && o_Word_Valid; i++) tick();
    n_checks++; if (o_Word_Valid !== 1'b0) begin n_fail++; $display("FAIL drain: valid=%b, required 0", o_Word_Valid); end
    tick();
  endtask
  task automatic end_frame(output logic d1, output logic d0, output logic [1:0] err, output logic [7:0] cmd);
    @(negedge i_Clock);
    d1 = o_Frame_Done;
    err = o_Err_Code;
    cmd = o_Cmd;
    @(negedge i_Clock);
    d0 = o_Frame_Done;
    drain();
  endtask
  task automatic test_reset();
    i_Reset = 1'b1;
    repeat (3) tick();
    @(negedge i_Clock);
    n_checks++; if (o_Busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b, required 0", o_Busy); end
    n_checks++; if (o_Word_Valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b, required 0", o_Word_Valid); end
    n_checks++; if (o_Frame_Done !== 1'b0) begin n_fail++; $display("FAIL rst_done: got %b, required 0", o_Frame_Done); end
    n_checks++; if (o_Err_Code !== 2'd0) begin n_fail++; $display("FAIL rst_err: got %0d, required 0", o_Err_Code); end
    n_checks++; if (o_Cmd !== 8'h00) begin n_fail++; $display("FAIL rst_cmd: got %h, required 00", o_Cmd); end
    n_checks++; if (o_Word !== 32'h0) begin n_fail++; $display("FAIL rst_word: got %h, required 0", o_Word); end
    tick();
    i_Reset = 1'b0;
    tick();
  endtask
  task automatic test_basic();
    bq_t b;
    wq_t w;
    logic [1:0] e, err;
    logic [7:0] c, cmd;
    logic d1, d0;
    b = {8'hA5, 8'h01, 8'h01, 8'h44, 8'h33, 8'h22, 8'h11, 8'h44};
    model(b, 1'b1, w, e, c);
    clear_obs();
    i_Word_Ready = 1'b1;
    for (int i = 0; i < 6; i++) send(b[i]);
    n_checks++; if (o_Word_Valid !== 1'b0) begin n_fail++; $display("FAIL basic_early_valid: got %b, required 0", o_Word_Valid); end
    send(b[6]);
    n_checks++; if (o_Word_Valid !== 1'b1) begin n_fail++; $display("FAIL basic_valid_latency: got %b, required 1", o_Word_Valid); end
    n_checks++; if (o_Word !== 32'h11223344) begin n_fail++; $display("FAIL basic_head_word: got %h, required 11223344", o_Word); end
    send(b[7]);
    end_frame(d1, d0, err, cmd);
    n_checks++; if (d1 !== 1'b1) begin n_fail++; $display("FAIL basic_done: got %b, required 1", d1); end
    n_checks++; if (d0 !== 1'b0) begin n_fail++; $display("FAIL basic_done_width: got %b, required 0", d0); end
    n_checks++; if (err !== e) begin n_fail++; $display("FAIL basic_err: got %0d, required %0d", err, e); end
    n_checks++; if (cmd !== c) begin n_fail++; $display("FAIL basic_cmd: got %h, required %h", cmd, c); end
    n_checks++; if (done_cnt !== 1) begin n_fail++; $display("FAIL basic_done_count: got %0d, required 1", done_cnt); end
    n_checks++; if (got_q.size() != w.size()) begin n_fail++; $display("FAIL basic_nwords: got %0d, required %0d", got_q.size(), w.size()); end
    for (int i = 0; i < w.size() && i < got_q.size(); i++) begin
      n_checks++; if (got_q[i] !== w[i]) begin n_fail++; $display("FAIL basic_word%0d: got %h, required %h", i, got_q[i], w[i]); end
    end
  endtask
  task automatic test_checksum();
    bq_t b;
    wq_t w;
    logic [1:0] e, err;
    logic [7:0] c, cmd;
    logic d1, d0;
    b = {8'hA5, 8'h01, 8'h01, 8'h44, 8'h33, 8'h22, 8'h11, 8'h45};
    model(b, 1'b1, w, e, c);
    clear_obs();
    send_frame(b, 0);
    end_frame(d1, d0, err, cmd);
    n_checks++; if (d1 !== 1'b1) begin n_fail++; $display("FAIL chk_done: got %b, required 1", d1); end
    n_checks++; if (err !== e) begin n_fail++; $display("FAIL chk_err: got %0d, required %0d", err, e); end
    n_checks++; if (got_q.size() != w.size()) begin n_fail++; $display("FAIL chk_nwords: got %0d, required %0d", got_q.size(), w.size()); end
    for (int i = 0; i < w.size() && i < got_q.size(); i++) begin
      n_checks++; if (got_q[i] !== w[i]) begin n_fail++; $display("FAIL chk_word%0d: got %h, required %h", i, got_q[i], w[i]); end
    end
  endtask
  task automatic test_zero_len();
    bq_t b;
    wq_t w;
    logic [1:0] e, err;
    logic [7:0] c, cmd;
    logic d1, d0;
    b = {8'hA5, 8'h07, 8'h00, 8'h07};
    model(b, 1'b1, w, e, c);
    clear_obs();
    send_frame(b, 1);
    end_frame(d1, d0, err, cmd);
    n_checks++; if (d1 !== 1'b1) begin n_fail++; $display("FAIL zlen_done: got %b, required 1", d1); end
    n_checks++; if (err !== e) begin n_fail++; $display("FAIL zlen_err: got %0d, required %0d", err, e); end
    n_checks++; if (cmd !== c) begin n_fail++; $display("FAIL zlen_cmd: got %h, required %h", cmd, c); end
    n_checks++; if (valid_seen !== 1'b0) begin n_fail++; $display("FAIL zlen_valid_seen: got %b, required 0", valid_seen); end
  endtask
  task automatic test_overflow();
    bq_t b;
    wq_t w;
    logic [1:0] e;
    logic [7:0] c;
    b = make_frame(8'h3C, 17, 1'b0);
    model(b, 1'b0, w, e, c);
    clear_obs();
    i_Word_Ready = 1'b0;
    send_frame(b, 0);
    @(negedge i_Clock);
    n_checks++; if (o_Frame_Done !== 1'b1) begin n_fail++; $display("FAIL ovf_done: got %b, required 1", o_Frame_Done); end
    n_checks++; if (o_Err_Code !== e) begin n_fail++; $display("FAIL ovf_err: got %0d, required %0d", o_Err_Code, e); end
    n_checks++; if (o_Word_Valid !== 1'b1) begin n_fail++; $display("FAIL ovf_held_valid: got %b, required 1", o_Word_Valid); end
    n_checks++; if (got_q.size() != 0) begin n_fail++; $display("FAIL ovf_no_pop: got %0d words, required 0", got_q.size()); end
    drain();
    n_checks++; if (got_q.size() != w.size()) begin n_fail++; $display("FAIL ovf_nwords: got %0d, required %0d", got_q.size(), w.size()); end
    for (int i = 0; i < w.size() && i < got_q.size(); i++) begin
      n_checks++; if (got_q[i] !== w[i]) begin n_fail++; $display("FAIL ovf_word%0d: got %h, required %h", i, got_q[i], w[i]); end
    end
  endtask
  task automatic test_timeout();
    bq_t b;
    wq_t w;
    logic [1:0] e, err;
    logic [7:0] c, cmd;
    logic d1, d0, seen, busy;
    int n;
    clear_obs();
    i_Word_Ready = 1'b1;
    send(8'hA5);
    send(8'h02);
    n_checks++; if (o_Busy !== 1'b1) begin n_fail++; $display("FAIL tmo_busy_before: got %b, required 1", o_Busy); end
    seen = 1'b0;
    n = 0;
    err = 2'd0;
    busy = 1'b1;
    for (int i = 1; i <= TMO + 20 && !seen; i++) begin
      @(negedge i_Clock);
      if (o_Frame_Done === 1'b1) begin
        seen = 1'b1;
        n = i;
        err = o_Err_Code;
        busy = o_Busy;
      end
    end
    n_checks++; if (seen !== 1'b1) begin n_fail++; $display("FAIL tmo_done: got no pulse within %0d clocks, required pulse", TMO + 20); end
    n_checks++; if (n < TMO - 1 || n > TMO + 2) begin n_fail++; $display("FAIL tmo_delay: got %0d clocks, required %0d..%0d", n, TMO - 1, TMO + 2); end
    n_checks++; if (err !== 2'd3) begin n_fail++; $display("FAIL tmo_err: got %0d, required 3", err); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL tmo_busy_after: got %b, required 0", busy); end
    tick();
    b = {8'hA5, 8'h01, 8'h01, 8'h44, 8'h33, 8'h22, 8'h11, 8'h44};
    model(b, 1'b1, w, e, c);
    clear_obs();
    send_frame(b, 2);
    end_frame(d1, d0, err, cmd);
    n_checks++; if (d1 !== 1'b1) begin n_fail++; $display("FAIL tmo_next_done: got %b, required 1", d1); end
    n_checks++; if (err !== e) begin n_fail++; $display("FAIL tmo_next_err: got %0d, required %0d", err, e); end
    n_checks++; if (got_q.size() != 1 || got_q[0] !== 32'h11223344) begin n_fail++; $display("FAIL tmo_next_word: got %0d words, required 1 word 11223344", got_q.size()); end
  endtask
  task automatic test_junk();
    bq_t b;
    wq_t w;
    logic [1:0] e, err;
    logic [7:0] c, cmd;
    logic d1, d0;
    b = {8'h00, 8'hFF, 8'h5A, 8'hA5, 8'h01, 8'h01, 8'h44, 8'h33, 8'h22, 8'h11, 8'h44};
    model(b, 1'b1, w, e, c);
    clear_obs();
    send_frame(b, 1);
    end_frame(d1, d0, err, cmd);
    n_checks++; if (done_cnt !== 1) begin n_fail++; $display("FAIL junk_done_count: got %0d, required 1", done_cnt); end
    n_checks++; if (err !== e) begin n_fail++; $display("FAIL junk_err: got %0d, required %0d", err, e); end
    n_checks++; if (cmd !== c) begin n_fail++; $display("FAIL junk_cmd: got %h, required %h", cmd, c); end
    n_checks++; if (got_q.size() != 1 || got_q[0] !== w[0]) begin n_fail++; $display("FAIL junk_word: got %0d words, required 1 word %h", got_q.size(), w[0]); end
    clear_obs();
    i_Word_Ready = 1'b0;
    b = make_frame(8'h09, 2, 1'b0);
    for (int i = 0; i < 9; i++) send(b[i]);
    n_checks++; if (o_Word_Valid !== 1'b1) begin n_fail++; $display("FAIL rstmid_pre_valid: got %b, required 1", o_Word_Valid); end
    i_Reset = 1'b1;
    tick();
    @(negedge i_Clock);
    n_checks++; if (o_Word_Valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_valid: got %b, required 0", o_Word_Valid); end
    n_checks++; if (o_Busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy: got %b, required 0", o_Busy); end
    n_checks++; if (o_Cmd !== 8'h00) begin n_fail++; $display("FAIL rstmid_cmd: got %h, required 00", o_Cmd); end
    n_checks++; if (o_Word !== 32'h0 || o_Err_Code !== 2'd0) begin n_fail++; $display("FAIL rstmid_word_err: got %h/%0d, required 0/0", o_Word, o_Err_Code); end
    tick();
    i_Reset = 1'b0;
    i_Word_Ready = 1'b1;
    repeat (5) tick();
    n_checks++; if (done_cnt !== 0) begin n_fail++; $display("FAIL rstmid_no_done: got %0d pulses, required 0", done_cnt); end
    n_checks++; if (o_Word_Valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_fifo_empty: got %b, required 0", o_Word_Valid); end
  endtask
  task automatic test_random();
    bq_t b;
    wq_t w;
    logic [1:0] e, err;
    logic [7:0] c, cmd;
    logic d1, d0;
    for (int f = 0; f < 25; f++) begin
      b = make_frame(8'($urandom), $urandom_range(0, 6), 1'($urandom_range(0, 1)));
      model(b, 1'b1, w, e, c);
      clear_obs();
      rand_ready = 1'b1;
      send_frame(b, 3);
      end_frame(d1, d0, err, cmd);
      n_checks++; if (d1 !== 1'b1 || d0 !== 1'b0) begin n_fail++; $display("FAIL rnd%0d_done: got %b%b, required 10", f, d1, d0); end
      n_checks++; if (err !== e) begin n_fail++; $display("FAIL rnd%0d_err: got %0d, required %0d", f, err, e); end
      n_checks++; if (cmd !== c) begin n_fail++; $display("FAIL rnd%0d_cmd: got %h, required %h", f, cmd, c); end
      n_checks++; if (got_q.size() != w.size()) begin n_fail++; $display("FAIL rnd%0d_nwords: got %0d, required %0d", f, got_q.size(), w.size()); end
      for (int i = 0; i < w.size() && i < got_q.size(); i++) begin
        n_checks++; if (got_q[i] !== w[i]) begin n_fail++; $display("FAIL rnd%0d_word%0d: got %h, required %h", f, i, got_q[i], w[i]); end
      end
    end
  endtask
  initial begin
    test_reset();
    test_basic();
    test_checksum();
    test_zero_len();
    test_overflow();
    test_timeout();
    test_junk();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
